waterfall_line_writer: RTL and testbench
========================================

Name: waterfall_line_writer

Overview:
- Downstream consumer of the sdft stage.
- On each line trigger it takes ownership of the sdft read port and sweeps all LIMIT_BINS magnitudes.
- Each magnitude is converted to a PIX_W-bit intensity and written as one row of a circular waterfall frame buffer, which the display scanner reads.
- While it owns the sdft it inhibits the upstream sample feeder's start pulses.

Parameters:
- LIMIT_BINS, 32, bins per line; power of two; must match sdft.
- FREQ_W, 16, sdft magnitude width.
- PIX_W, 4, pixel intensity width.
- ROWS, 16, rows in the frame buffer; power of two.
- SHIFT, 4, linear-mode right shift applied to the magnitude.
- READ_LAT, 2, cycles from sdft_bin_addr presented (sdft in read state) to the matching sdft_bin_out.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- line_tick  in  1  single-cycle request to capture one spectrum line
- sdft_ready  in  1  sdft idle/waiting
- sdft_bin_out  in  FREQ_W  sdft magnitude
- sdft_read  out  1  sdft read request
- sdft_bin_addr  out  clog2(LIMIT_BINS)  bin index to sdft
- hold_start  out  1  high = upstream must not pulse sdft start
- wr_en  out  1  frame buffer write strobe
- wr_addr  out  clog2(ROWS)+clog2(LIMIT_BINS)  {row_ptr, bin}
- wr_data  out  PIX_W  pixel intensity
- row_ptr  out  clog2(ROWS)  row being / next to be written
- line_done  out  1  one-cycle pulse after the last write of a row
- overrun  out  1  one-cycle pulse when line_tick is dropped

Behaviour:
- Reset values: all outputs 0; state IDLE; row_ptr 0; pending flag 0; valid pipe cleared. Reset mid-line aborts immediately and drops sdft_read. No partial-row recovery.
- States:
  - IDLE: if line_tick or pending, go to REQ; clear pending.
  - REQ: sdft_read=1, hold_start=1, sdft_bin_addr=0. When sdft_ready=1 at a clock edge, go to ISSUE next cycle (sdft enters its read state on that same edge).
  - ISSUE: drive sdft_bin_addr = k for k = 0..LIMIT_BINS-1, one per cycle. sdft_read=1 except on the k=LIMIT_BINS-1 cycle, where it is 0 so sdft returns to wait. Push a valid token tagged k into a READ_LAT-deep pipe each cycle. After the last address, go to DRAIN.
  - DRAIN: wait until the pipe is empty, then go to DONE.
  - DONE: line_done=1; row_ptr increments, wrapping ROWS-1 to 0; go to IDLE.
- hold_start is 1 in REQ, ISSUE and DRAIN; 0 otherwise. Upstream guarantees start is not asserted in the cycle hold_start rises, so sdft read never collides with start. If both reach sdft, read wins.
- Write path: when a token tagged k exits the pipe, in the same cycle:
  - wr_en=1
  - wr_addr={row_ptr,k}
  - wr_data=pix(sdft_bin_out)
  - Exactly LIMIT_BINS writes per line, bins ascending, contiguous cycles.
- Linear pix: m = sdft_bin_out >> SHIFT; saturate to 2^PIX_W-1 if m exceeds it.
- Latency: line_tick in IDLE with sdft_ready=1 gives the first write 2+READ_LAT cycles later. line_done follows LIMIT_BINS-1 cycles after the first write, plus 1.
- line_tick while not IDLE:
  - pending=0: set pending.
  - pending=1: the tick is dropped and overrun pulses.
  - line_tick in DONE counts as while busy.
- sdft_ready low in REQ: wait indefinitely with read held. No timeout.

Optional Feature:
- Macro: WATERFALL_LOG_SCALE_EN.
- Defined: pix = index of the most-significant set bit of sdft_bin_out, plus 1, saturated to 2^PIX_W-1; 0 when the magnitude is 0. SHIFT is ignored. Latency unchanged; the conversion stays combinational on the write cycle.
- Undefined: linear pix only.

Test Plan:
- Reset, then one line_tick with sdft model ready and bin_out = 16*k: 32 writes; wr_data = min(k,15); wr_addr 0..31; first write 4 cycles after tick; line_done after the 32nd write; row_ptr then 1.
- 16 consecutive lines: row_ptr wraps 15 to 0; line 17 writes wr_addr 0..31 again.
- sdft_ready low for 50 cycles after tick: sdft_read and hold_start held; sdft_bin_addr=0; no writes; sweep proceeds normally after ready rises.
- Two ticks during a sweep: first sets pending and the next line starts right after DONE; second pulses overrun once; total lines = 2.
- reset asserted at the 10th write: next cycle all outputs 0, sdft_read 0; a following tick performs a full 32-write line into row 0.
- With WATERFALL_LOG_SCALE_EN, bin_out values 0, 1, 0x00FF, 0xFFFF give pix 0, 1, 8, 15.

Source files
------------

// File: rtl/waterfall_line_writer_if.sv
// rtl/waterfall_line_writer_if.sv - sdft read port and frame buffer write port bundle
//
// Purpose: groups the handshake/bus signals of waterfall_line_writer.
//   sdft side    : sdft_ready, sdft_bin_out (to writer); sdft_read,
//                  sdft_bin_addr, hold_start (from writer)
//   frame buffer : wr_en, wr_addr, wr_data (from writer)
// Modports: master = the line writer, slave = sdft / frame buffer / feeder.

interface waterfall_line_writer_if #(
   parameter int FREQ_W = 16,
   parameter int BIN_W  = 5,
   parameter int PIX_W  = 4,
   parameter int ADDR_W = 9
);
   logic              sdft_ready;
   logic [FREQ_W-1:0] sdft_bin_out;
   logic              sdft_read;
   logic [BIN_W-1:0]  sdft_bin_addr;
   logic              hold_start;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [PIX_W-1:0]  wr_data;

   modport master (
      input  sdft_ready, sdft_bin_out,
      output sdft_read, sdft_bin_addr, hold_start,
      output wr_en, wr_addr, wr_data
   );

   modport slave (
      output sdft_ready, sdft_bin_out,
      input  sdft_read, sdft_bin_addr, hold_start,
      input  wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/waterfall_line_writer.sv
// rtl/waterfall_line_writer.sv - sweeps sdft magnitudes into one row of a circular waterfall buffer
//
// Purpose: on each line_tick, owns the sdft read port, reads all LIMIT_BINS
// magnitudes, converts each to a PIX_W-bit intensity and writes them as one
// row of the frame buffer at {row_ptr, bin}. Upstream start pulses are held
// off while the sweep owns the sdft.
//
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   line_tick    one-cycle request to capture a spectrum line
//   bus          waterfall_line_writer_if.master (sdft read port + frame buffer write port)
//   row_ptr      row being / next to be written
//   line_done    one-cycle pulse after the last write of a row
//   overrun      one-cycle pulse when a line_tick is dropped
//
// Build option: WATERFALL_LOG_SCALE_EN selects log2 intensity (MSB position + 1)
// instead of the linear shift-and-saturate conversion.

module waterfall_line_writer #(
   parameter int LIMIT_BINS = 32,
   parameter int FREQ_W     = 16,
   parameter int PIX_W      = 4,
   parameter int ROWS       = 16,
   parameter int SHIFT      = 4,
   parameter int READ_LAT   = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          line_tick,
   waterfall_line_writer_if.master       bus,
   output logic [$clog2(ROWS)-1:0]       row_ptr,
   output logic                          line_done,
   output logic                          overrun
);

   localparam int BIN_W     = $clog2(LIMIT_BINS);
   localparam int ROW_W     = $clog2(ROWS);
   localparam int PIX_MAX_I = (1 << PIX_W) - 1;
   localparam logic [BIN_W-1:0]    LAST_K    = BIN_W'(LIMIT_BINS - 1);
   localparam logic [READ_LAT-1:0] LAST_MASK = READ_LAT'(1) << (READ_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t            state, state_n;
   logic [BIN_W-1:0]  k_cnt;
   logic              pending;
   logic              issue;
   logic              upstream_busy;
   logic [PIX_W-1:0]  pix;

   // Valid/tag pipe that tracks each issued address until its magnitude
   // arrives READ_LAT cycles later.
   logic [READ_LAT-1:0] pipe_v;
   logic [BIN_W-1:0]    pipe_tag [READ_LAT];

   // Tokens still in flight other than the one exiting this cycle.
   assign upstream_busy = |(pipe_v & ~LAST_MASK);

   // ------------------------------------------------------------------
   // State register and sweep counters
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         k_cnt   <= '0;
         row_ptr <= '0;
         pending <= 1'b0;
      end else begin
         state <= state_n;

         if (state == S_ISSUE) begin
            k_cnt <= k_cnt + 1'b1;
         end else begin
            k_cnt <= '0;
         end

         if (state == S_DONE) begin
            row_ptr <= row_ptr + 1'b1;
         end

         // One request may queue behind a busy sweep; IDLE consumes it.
         if (state == S_IDLE) begin
            pending <= 1'b0;
         end else if (line_tick && !pending) begin
            pending <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pipe_v <= '0;
         for (int i = 0; i < READ_LAT; i++) begin
            pipe_tag[i] <= '0;
         end
      end else begin
         pipe_v[0]   <= issue;
         pipe_tag[0] <= k_cnt;
         for (int i = 1; i < READ_LAT; i++) begin
            pipe_v[i]   <= pipe_v[i-1];
            pipe_tag[i] <= pipe_tag[i-1];
         end
      end
   end

   // ------------------------------------------------------------------
   // Next state and sdft-side outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_n           = state;
      issue             = 1'b0;
      line_done         = 1'b0;
      bus.sdft_read     = 1'b0;
      bus.sdft_bin_addr = '0;
      bus.hold_start    = 1'b0;

      case (state)
         S_IDLE: begin
            if (line_tick || pending) begin
               state_n = S_REQ;
            end
         end
         S_REQ: begin
            bus.sdft_read  = 1'b1;
            bus.hold_start = 1'b1;
            // sdft moves to its read state on the same edge it sees ready.
            if (bus.sdft_ready) begin
               state_n = S_ISSUE;
            end
         end
         S_ISSUE: begin
            bus.hold_start    = 1'b1;
            bus.sdft_bin_addr = k_cnt;
            issue             = 1'b1;
            // Dropping read on the final address returns sdft to wait.
            bus.sdft_read     = (k_cnt != LAST_K);
            if (k_cnt == LAST_K) begin
               state_n = S_DRAIN;
            end
         end
         S_DRAIN: begin
            bus.hold_start = 1'b1;
            // The last write happens in this cycle if only the exit stage
            // is occupied, so DONE lands the cycle after it.
            if (!upstream_busy) begin
               state_n = S_DONE;
            end
         end
         S_DONE: begin
            line_done = 1'b1;
            state_n   = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   assign overrun = line_tick && (state != S_IDLE) && pending;

   // ------------------------------------------------------------------
   // Magnitude to intensity conversion (combinational on the write cycle)
   // ------------------------------------------------------------------
`ifdef WATERFALL_LOG_SCALE_EN
   int bit_len;

   always_comb begin
      bit_len = 0;
      for (int i = 0; i < FREQ_W; i++) begin
         if (bus.sdft_bin_out[i]) begin
            bit_len = i + 1;
         end
      end
      if (bit_len > PIX_MAX_I) begin
         pix = '1;
      end else begin
         pix = PIX_W'(bit_len);
      end
   end
`else
   logic [FREQ_W-1:0] mag_shift;

   always_comb begin
      mag_shift = bus.sdft_bin_out >> SHIFT;
      if (mag_shift > FREQ_W'(PIX_MAX_I)) begin
         pix = '1;
      end else begin
         pix = mag_shift[PIX_W-1:0];
      end
   end
`endif

   // ------------------------------------------------------------------
   // Frame buffer write port
   // ------------------------------------------------------------------
   assign bus.wr_en   = pipe_v[READ_LAT-1];
   assign bus.wr_addr = {row_ptr, pipe_tag[READ_LAT-1]};
   assign bus.wr_data = bus.wr_en ? pix : '0;

endmodule

// File: tb/tb_waterfall_line_writer.sv
// tb/tb_waterfall_line_writer.sv - self-checking bench for waterfall_line_writer

module tb_waterfall_line_writer;

   localparam int BINS = 32;
   localparam int ROWS = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       line_tick = 1'b0;
   logic [3:0] row_ptr;
   logic       line_done;
   logic       overrun;

   waterfall_line_writer_if #(.FREQ_W(16), .BIN_W(5), .PIX_W(4), .ADDR_W(9)) bus ();

   waterfall_line_writer #(
      .LIMIT_BINS(BINS), .FREQ_W(16), .PIX_W(4), .ROWS(ROWS), .SHIFT(4), .READ_LAT(2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .line_tick (line_tick),
      .bus       (bus),
      .row_ptr   (row_ptr),
      .line_done (line_done),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   bit rst_q = 1'b1;
   int mode = 0;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= reset;
   end

   // Magnitude the sdft holds for bin k under the current stimulus pattern.
   function automatic int val(int k);
      case (mode)
         0: return 16 * k;
         1: return (k * 2111) & 16'hFFFF;
         default: begin
            case (k)
               0: return 0;
               1: return 1;
               2: return 'h00FF;
               3: return 'hFFFF;
               default: return (k * k * 60) & 16'hFFFF;
            endcase
         end
      endcase
   endfunction

   function automatic int pix_model(int v);
      int b;
`ifdef WATERFALL_LOG_SCALE_EN
      b = 0;
      while ((v >> b) != 0) b++;
`else
      b = v / 16;
`endif
      return (b > 15) ? 15 : b;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // sdft read port: address seen in one cycle returns data two cycles later.
   logic [4:0] a_d1 = '0;
   logic [4:0] a_d2 = '0;
   always @(posedge clk) begin
      a_d2 = a_d1;
      a_d1 = bus.sdft_bin_addr;
      bus.sdft_bin_out = 16'(val(int'(a_d2)));
   end

   // Scoreboard: expected row/bin progression of writes and line_done.
   int m_row = 0;
   int m_bin = 0;
   bit m_done_due = 1'b0;
   int lines_done = 0;
   int ov_count = 0;
   int first_wr_cyc = 0;
   int done_cyc = 0;
   int cap_data [BINS];
   int cap_addr [BINS];

   always @(negedge clk) begin
      if (rst_q) begin
         chk("rst_sdft_read", bus.sdft_read, 0);
         chk("rst_hold_start", bus.hold_start, 0);
         chk("rst_bin_addr", bus.sdft_bin_addr, 0);
         chk("rst_wr_en", bus.wr_en, 0);
         chk("rst_wr_addr", bus.wr_addr, 0);
         chk("rst_wr_data", bus.wr_data, 0);
         chk("rst_row_ptr", row_ptr, 0);
         chk("rst_line_done", line_done, 0);
         chk("rst_overrun", overrun, 0);
         m_row = 0;
         m_bin = 0;
         m_done_due = 1'b0;
      end else begin
         chk("row_ptr", row_ptr, m_row);
         chk("line_done", line_done, m_done_due);
         if (m_done_due) begin
            m_row = (m_row + 1) % ROWS;
            m_done_due = 1'b0;
            lines_done++;
            done_cyc = cyc;
         end
         if (m_bin != 0) chk("contig_wr_en", bus.wr_en, 1);
         if (bus.wr_en) begin
            if (m_bin == 0) first_wr_cyc = cyc;
            chk("wr_addr", bus.wr_addr, m_row * BINS + m_bin);
            chk("wr_data", bus.wr_data, pix_model(val(m_bin)));
            chk("hold_during_write", bus.hold_start, 1);
            cap_data[m_bin] = int'(bus.wr_data);
            cap_addr[m_bin] = int'(bus.wr_addr);
            m_bin++;
            if (m_bin == BINS) begin
               m_bin = 0;
               m_done_due = 1'b1;
            end
         end
         if (overrun) ov_count++;
      end
   end

   int tick_cyc = 0;

   task automatic pulse_tick();
      @(posedge clk);
      #1 line_tick = 1'b1;
      tick_cyc = cyc;
      @(posedge clk);
      #1 line_tick = 1'b0;
   endtask

   task automatic wait_lines(int target, int budget, string name);
      int n = 0;
      while (lines_done < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      chk(name, lines_done, target);
   endtask

   initial begin
      int d;
      int b;
      int n;
      bus.sdft_ready = 1'b1;
      bus.sdft_bin_out = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Single line, magnitudes 16*k
      mode = 0;
      pulse_tick();
      wait_lines(1, 200, "line1_done");
      chk("first_write_latency", first_wr_cyc - tick_cyc, 4);
      chk("done_after_first_write", done_cyc - first_wr_cyc, 32);
      chk("line1_bin5_data", cap_data[5], 5);
      chk("line1_bin31_data", cap_data[31], 15);
      chk("line1_bin0_addr", cap_addr[0], 0);
      chk("line1_bin31_addr", cap_addr[31], 31);
      @(negedge clk);
      chk("row_ptr_after_line1", row_ptr, 1);

      // Fifteen more lines: row_ptr wraps back to 0
      for (int i = 0; i < 15; i++) begin
         mode = (i % 2 == 1) ? 1 : 0;
         pulse_tick();
         wait_lines(i + 2, 200, "wrap_line_done");
      end
      @(negedge clk);
      chk("row_ptr_wrapped", row_ptr, 0);
      mode = 0;
      pulse_tick();
      wait_lines(17, 200, "line17_done");
      chk("line17_bin0_addr", cap_addr[0], 0);
      chk("line17_bin31_addr", cap_addr[31], 31);

      // sdft not ready for 50 cycles
      bus.sdft_ready = 1'b0;
      pulse_tick();
      repeat (50) begin
         @(negedge clk);
         chk("stall_sdft_read", bus.sdft_read, 1);
         chk("stall_hold_start", bus.hold_start, 1);
         chk("stall_bin_addr", bus.sdft_bin_addr, 0);
         chk("stall_no_write", bus.wr_en, 0);
      end
      bus.sdft_ready = 1'b1;
      wait_lines(18, 200, "stall_line_done");
      chk("stall_row_ptr_line", cap_addr[31], 1 * BINS + 31);

      // Two ticks during a sweep: one pending, one dropped
      mode = 2;
      ov_count = 0;
      pulse_tick();
      b = 0;
      while (m_bin == 0 && b < 100) begin
         @(negedge clk);
         b++;
      end
      chk("sweep_started", (m_bin != 0), 1);
      pulse_tick();
      repeat (5) @(posedge clk);
      pulse_tick();
      wait_lines(19, 300, "busy_line1_done");
      d = done_cyc;
      wait_lines(20, 300, "busy_line2_done");
      chk("pending_restart_gap", first_wr_cyc - d, 5);
      chk("overrun_once", ov_count, 1);
`ifdef WATERFALL_LOG_SCALE_EN
      chk("log_pix_0", cap_data[0], 0);
      chk("log_pix_1", cap_data[1], 1);
      chk("log_pix_ff", cap_data[2], 8);
      chk("log_pix_ffff", cap_data[3], 15);
`else
      chk("lin_pix_0", cap_data[0], 0);
      chk("lin_pix_1", cap_data[1], 0);
      chk("lin_pix_ff", cap_data[2], 15);
      chk("lin_pix_ffff", cap_data[3], 15);
`endif
      repeat (100) @(posedge clk);
      chk("no_third_line", lines_done, 20);
      chk("overrun_still_once", ov_count, 1);

      // Reset at the 10th write, then a full line into row 0
      mode = 0;
      pulse_tick();
      n = 0;
      b = 0;
      while (n < 10 && b < 200) begin
         @(negedge clk);
         b++;
         if (bus.wr_en) n++;
      end
      chk("reached_10th_write", n, 10);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_drops_read", bus.sdft_read, 0);
      chk("reset_row_ptr", row_ptr, 0);
      pulse_tick();
      wait_lines(21, 200, "post_reset_line_done");
      chk("post_reset_bin0_addr", cap_addr[0], 0);
      chk("post_reset_bin31_addr", cap_addr[31], 31);
      chk("post_reset_bin9_data", cap_data[9], 9);
      @(negedge clk);
      chk("post_reset_row_ptr", row_ptr, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
